// File: rtl/adler32_checker.sv
// Adler-32 receive-side checker.
// Consumes payload bytes followed by a 4-byte big-endian Adler-32 trailer,
// recomputes the checksum at one byte per cycle and holds a pass/fail verdict
// plus the computed sum until the consumer takes it.
module adler32_checker #(
  parameter int unsigned MOD_BASE = 65521,
  parameter int unsigned INIT_A   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_pass,
  output logic [31:0] result_sum
);

  typedef enum logic [1:0] {
    S_DATA    = 2'd0,
    S_TRAILER = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  // Sums are kept 17 bits wide so the pre-reduction value cannot overflow.
  localparam logic [16:0] MOD  = 17'(MOD_BASE);
  localparam logic [16:0] INIT = 17'(INIT_A);

  state_t      state;
  logic [16:0] sum_a;
  logic [16:0] sum_b;
  logic [31:0] trailer;
  logic [1:0]  count;

  logic        beat;
  logic [16:0] a_raw;
  logic [16:0] a_next;
  logic [16:0] b_raw;
  logic [16:0] b_next;
  logic [31:0] trailer_next;
  logic [31:0] sum_word;

  // Ready depends only on state so the upstream never sees a combinational path
  // from its own valid.
  always_comb begin
    in_ready = (state != S_RESULT);
    beat     = in_valid & in_ready;
  end

  // One Adler step: both sums stay below MOD, so their sum with a byte (or with
  // each other) stays below 2*MOD and a single conditional subtract reduces it.
  always_comb begin
    a_raw        = sum_a + {9'd0, in_data};
    a_next       = (a_raw >= MOD) ? (a_raw - MOD) : a_raw;
    b_raw        = sum_b + a_next;
    b_next       = (b_raw >= MOD) ? (b_raw - MOD) : b_raw;
    trailer_next = {trailer[23:0], in_data};
    sum_word     = {sum_b[15:0], sum_a[15:0]};
  end

  // Frame FSM: accumulate payload, collect trailer, then hold the verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_DATA;
      sum_a        <= INIT;
      sum_b        <= 17'd0;
      trailer      <= 32'd0;
      count        <= 2'd0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
      result_sum   <= 32'd0;
    end else begin
      case (state)
        S_DATA: begin
          if (beat) begin
            sum_a <= a_next;
            sum_b <= b_next;
            if (in_last) begin
              state <= S_TRAILER;
              count <= 2'd0;
            end
          end
        end
        S_TRAILER: begin
          // in_last is meaningless here; exactly four trailer bytes end the frame.
          if (beat) begin
            trailer <= trailer_next;
            count   <= count + 2'd1;
            if (count == 2'd3) begin
              state        <= S_RESULT;
              result_valid <= 1'b1;
              result_sum   <= sum_word;
              result_pass  <= (sum_word == trailer_next);
            end
          end
        end
        S_RESULT: begin
          // Verdict registers keep their last value after the handshake.
          if (result_ready) begin
            state        <= S_DATA;
            result_valid <= 1'b0;
            sum_a        <= INIT;
            sum_b        <= 17'd0;
          end
        end
        default: begin
          state <= S_DATA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adler32_checker.sv
// Directed bench for adler32_checker: known-answer frames, latency, back-pressure
// on the verdict and reset in the middle of a trailer.
module tb_adler32_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        result_valid;
  logic        result_ready;
  logic        result_pass;
  logic [31:0] result_sum;

  int checks = 0;
  int errors = 0;

  adler32_checker #(.MOD_BASE(65521), .INIT_A(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_pass  (result_pass),
    .result_sum   (result_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Present one byte and hold it until a beat happens (bounded wait).
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Trailer bytes go out with in_last=1 to confirm it is ignored there.
  task automatic send_trailer(input logic [31:0] t);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = t[i*8 +: 8];
      send_byte(b, 1'b1);
    end
  endtask

  task automatic take_result(input string tag, input logic pass, input logic [31:0] sum);
    int n;
    n = 0;
    while (!result_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " valid"}, {31'd0, result_valid}, 32'd1);
    chk({tag, " pass"},  {31'd0, result_pass},  {31'd0, pass});
    chk({tag, " sum"},   result_sum, sum);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({tag, " valid drop"}, {31'd0, result_valid}, 32'd0);
    chk({tag, " ready back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    string wiki;
    logic [31:0] held;
    wiki         = "Wikipedia";
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = 8'd0;
    in_last      = 1'b0;
    result_ready = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state
    chk("rst valid", {31'd0, result_valid}, 32'd0);
    chk("rst pass",  {31'd0, result_pass},  32'd0);
    chk("rst sum",   result_sum, 32'd0);
    chk("rst ready", {31'd0, in_ready}, 32'd1);

    // 1: "Wikipedia"
    for (int i = 0; i < 9; i++) send_byte(wiki[i], (i == 8));
    send_trailer(32'h11E60398);
    take_result("wiki", 1'b1, 32'h11E60398);

    // 2: single 0x00, good and bad trailer
    send_byte(8'h00, 1'b1);
    send_trailer(32'h00010001);
    take_result("zero ok", 1'b1, 32'h00010001);
    send_byte(8'h00, 1'b1);
    send_trailer(32'h00010002);
    take_result("zero bad", 1'b0, 32'h00010001);

    // 3: single 0xFF with exact verdict latency
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("lat before", {31'd0, result_valid}, 32'd0);
    send_byte(8'h00, 1'b0);
    chk("lat after", {31'd0, result_valid}, 32'd1);
    take_result("ff", 1'b1, 32'h01000100);

    // 4: 257 x 0xFF with random gaps; A = 65536 mod 65521 = 15, B = 8454272 mod 65521 = 2063
    for (int i = 0; i < 257; i++) begin
      idle($urandom_range(0, 2));
      send_byte(8'hFF, (i == 256));
    end
    idle(1);
    send_trailer(32'h080F000F);
    take_result("long", 1'b1, 32'h080F000F);

    // 5: verdict held under back-pressure, then next frame restarts from A=1,B=0
    send_byte(8'hFF, 1'b1);
    send_trailer(32'h01000100);
    held = result_sum;
    for (int i = 0; i < 10; i++) begin
      chk("hold ready", {31'd0, in_ready}, 32'd0);
      chk("hold valid", {31'd0, result_valid}, 32'd1);
      chk("hold sum", result_sum, 32'h01000100);
      idle(1);
    end
    chk("hold stable", result_sum, held);
    take_result("hold", 1'b1, 32'h01000100);
    send_byte(8'h00, 1'b1);
    send_trailer(32'h00010001);
    take_result("after hold", 1'b1, 32'h00010001);

    // 6: reset after two trailer bytes aborts the frame
    send_byte(8'h37, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h38, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort valid", {31'd0, result_valid}, 32'd0);
      chk("abort ready", {31'd0, in_ready}, 32'd1);
      idle(1);
    end
    send_byte(8'h00, 1'b1);
    send_trailer(32'h00010001);
    take_result("post rst", 1'b1, 32'h00010001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
